// File: rtl/pktfifo_mem.sv
// Simple dual-port RAM behind pktfifo: one write port and one read port.
// The read port is either combinational or a reset-able registered read.
module pktfifo_mem #(
    parameter int DW             = 33,
    parameter int AW             = 9,
    parameter int OPT_ASYNC_READ = 0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_wr,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rd,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge i_clk)
        if (i_wr)
            mem[i_waddr] <= i_wdata;

    generate
        if (OPT_ASYNC_READ != 0) begin : g_async
            logic unused_ok;
            assign unused_ok = &{1'b0, i_rd, i_reset_n};
            assign o_rdata   = mem[i_raddr];
        end else begin : g_sync
            // Only the read register is reset; array contents are don't-care until written.
            always_ff @(posedge i_clk)
                if (!i_reset_n)
                    o_rdata <= '0;
                else if (i_rd)
                    o_rdata <= mem[i_raddr];
        end
    endgenerate
endmodule

// File: rtl/pktfifo.sv
// Packet FIFO with commit/abort on the write side: words become readable only once the
// packet's LAST word is accepted, so a failed block can be discarded before any reader sees it.
module pktfifo #(
    parameter int BW             = 32,
    parameter int LGFLEN         = 9,
    parameter int OPT_ASYNC_READ = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [BW-1:0]     i_data,
    input  logic              i_last,
    input  logic              i_abort,
    input  logic [LGFLEN:0]   i_afull_thresh,
    output logic              o_full,
    output logic              o_afull,
    output logic [LGFLEN:0]   o_wr_fill,
    output logic              o_overflow,
    input  logic              i_rd,
    output logic [BW-1:0]     o_data,
    output logic              o_last,
    output logic              o_empty,
    output logic [LGFLEN:0]   o_rd_fill,
    output logic [LGFLEN:0]   o_pkts
);
    localparam int            FLEN   = 1 << LGFLEN;
    localparam int            PW     = LGFLEN + 1;
    localparam logic [PW-1:0] FLEN_W = PW'(FLEN);
    localparam logic [PW-1:0] ONE    = PW'(1);

    logic [PW-1:0]     wr_ptr, cm_ptr, rd_ptr, pkts;
    logic              dropping, overflow;
    logic              accept, commit, pop, mem_rd;
    logic [LGFLEN-1:0] mem_raddr;
    logic [BW:0]       rdata;

    assign o_wr_fill  = wr_ptr - rd_ptr;
    assign o_rd_fill  = cm_ptr - rd_ptr;
    assign o_full     = (o_wr_fill == FLEN_W);
    assign o_afull    = (o_wr_fill >= i_afull_thresh);
    assign o_overflow = overflow;
    assign o_pkts     = pkts;

    assign accept = i_wr && !o_full && !dropping && !i_abort;
    assign commit = accept && i_last;
    assign pop    = i_rd && !o_empty;

    // Abort outranks everything; an overflowing packet rewinds to the commit point and the
    // rest of it, up to and including its LAST word, is swallowed.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            dropping <= 1'b0;
            overflow <= 1'b0;
        end else if (i_abort) begin
            wr_ptr   <= cm_ptr;
            dropping <= 1'b0;
        end else if (dropping) begin
            if (i_wr && i_last)
                dropping <= 1'b0;
        end else if (i_wr && o_full) begin
            overflow <= 1'b1;
            wr_ptr   <= cm_ptr;
            dropping <= !i_last;
        end else if (accept) begin
            wr_ptr <= wr_ptr + ONE;
            if (i_last)
                cm_ptr <= wr_ptr + ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            pkts   <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + ONE;
            if (commit && !(pop && o_last))
                pkts <= pkts + ONE;
            else if (!commit && pop && o_last)
                pkts <= pkts - ONE;
        end
    end

    generate
        if (OPT_ASYNC_READ != 0) begin : g_async
            assign mem_raddr = rd_ptr[LGFLEN-1:0];
            assign mem_rd    = 1'b0;
            assign o_empty   = (cm_ptr == rd_ptr);
        end else begin : g_sync
            logic          out_valid, load;
            logic [PW-1:0] fetch_ptr;

            // rd_ptr names the head word held in the output register, so the next fetch
            // comes from one past it whenever the register is occupied.
            assign fetch_ptr = rd_ptr + {{LGFLEN{1'b0}}, out_valid};
            assign load      = (!out_valid || pop) && (cm_ptr != fetch_ptr);
            assign mem_raddr = fetch_ptr[LGFLEN-1:0];
            assign mem_rd    = load;
            assign o_empty   = !out_valid;

            always_ff @(posedge i_clk)
                if (!i_reset_n)
                    out_valid <= 1'b0;
                else if (load)
                    out_valid <= 1'b1;
                else if (pop)
                    out_valid <= 1'b0;
        end
    endgenerate

    assign o_data = o_empty ? '0 : rdata[BW-1:0];
    assign o_last = !o_empty && rdata[BW];

    pktfifo_mem #(
        .DW             (BW + 1),
        .AW             (LGFLEN),
        .OPT_ASYNC_READ (OPT_ASYNC_READ)
    ) u_mem (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr      (accept),
        .i_waddr   (wr_ptr[LGFLEN-1:0]),
        .i_wdata   ({i_last, i_data}),
        .i_rd      (mem_rd),
        .i_raddr   (mem_raddr),
        .o_rdata   (rdata)
    );
endmodule

// File: tb/tb_pktfifo.sv
// Scoreboard bench for pktfifo: an async-read and a registered-read instance (16 deep) share
// the write side; committed words go into per-instance queues checked by a negedge monitor.
module tb_pktfifo;
    localparam int BW   = 32;
    localparam int LG   = 4;
    localparam int FLEN = 1 << LG;
    localparam int PW   = LG + 1;

    logic          clk = 1'b0;
    logic          reset_n, wr, last, abort, rd_a, rd_s;
    logic [BW-1:0] data;
    logic [PW-1:0] thresh;

    logic          full_a, afull_a, overflow_a, empty_a, last_a;
    logic [PW-1:0] wr_fill_a, rd_fill_a, pkts_a;
    logic [BW-1:0] data_a;
    logic          full_s, afull_s, overflow_s, empty_s, last_s;
    logic [PW-1:0] wr_fill_s, rd_fill_s, pkts_s;
    logic [BW-1:0] data_s;

    int          errors = 0;
    int          checks = 0;
    logic [BW:0] q_a[$];
    logic [BW:0] q_s[$];
    logic [BW:0] w_a, w_s;
    int          exp_pkts_a = 0;
    int          exp_pkts_s = 0;
    bit          track_pkts = 1'b0;
    bit          seen_full  = 1'b0;

    always #5 clk = ~clk;

    pktfifo #(.BW(BW), .LGFLEN(LG), .OPT_ASYNC_READ(1)) dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_wr(wr), .i_data(data), .i_last(last),
        .i_abort(abort), .i_afull_thresh(thresh), .o_full(full_a), .o_afull(afull_a),
        .o_wr_fill(wr_fill_a), .o_overflow(overflow_a), .i_rd(rd_a), .o_data(data_a),
        .o_last(last_a), .o_empty(empty_a), .o_rd_fill(rd_fill_a), .o_pkts(pkts_a)
    );

    pktfifo #(.BW(BW), .LGFLEN(LG), .OPT_ASYNC_READ(0)) dut_s (
        .i_clk(clk), .i_reset_n(reset_n), .i_wr(wr), .i_data(data), .i_last(last),
        .i_abort(abort), .i_afull_thresh(thresh), .o_full(full_s), .o_afull(afull_s),
        .o_wr_fill(wr_fill_s), .o_overflow(overflow_s), .i_rd(rd_s), .o_data(data_s),
        .o_last(last_s), .o_empty(empty_s), .o_rd_fill(rd_fill_s), .o_pkts(pkts_s)
    );

    task automatic check_output(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [BW-1:0] d, input logic l);
        wr   = 1'b1;
        data = d;
        last = l;
        tick();
        wr   = 1'b0;
        last = 1'b0;
        data = '0;
    endtask

    task automatic push_word(input logic [BW:0] w);
        q_a.push_back(w);
        q_s.push_back(w);
        if (w[BW]) begin
            exp_pkts_a++;
            exp_pkts_s++;
        end
    endtask

    // Words enter the scoreboard only after the commit edge, matching when they become readable.
    task automatic send_pkt(input logic [BW-1:0] base, input int n);
        logic [BW:0]   pend[$];
        logic [BW-1:0] d;
        logic          l;
        for (int i = 0; i < n; i++) begin
            d = base + BW'(i);
            l = (i == n - 1);
            put_word(d, l);
            pend.push_back({l, d});
        end
        foreach (pend[i])
            push_word(pend[i]);
    endtask

    task automatic drain();
        logic ok;
        ok   = 1'b0;
        rd_a = 1'b1;
        rd_s = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (empty_a && empty_s && q_a.size() == 0 && q_s.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        rd_a = 1'b0;
        rd_s = 1'b0;
        check_output("drain_complete", ok, 1'b1);
    endtask

    task automatic check_reset(input logic exp_afull);
        check_output("rst_full_a", full_a, 0);
        check_output("rst_afull_a", afull_a, exp_afull);
        check_output("rst_wr_fill_a", wr_fill_a, 0);
        check_output("rst_overflow_a", overflow_a, 0);
        check_output("rst_empty_a", empty_a, 1);
        check_output("rst_rd_fill_a", rd_fill_a, 0);
        check_output("rst_pkts_a", pkts_a, 0);
        check_output("rst_data_a", data_a, 0);
        check_output("rst_last_a", last_a, 0);
        check_output("rst_full_s", full_s, 0);
        check_output("rst_afull_s", afull_s, exp_afull);
        check_output("rst_wr_fill_s", wr_fill_s, 0);
        check_output("rst_overflow_s", overflow_s, 0);
        check_output("rst_empty_s", empty_s, 1);
        check_output("rst_rd_fill_s", rd_fill_s, 0);
        check_output("rst_pkts_s", pkts_s, 0);
        check_output("rst_data_s", data_s, 0);
        check_output("rst_last_s", last_s, 0);
    endtask

    // Monitor: every pop is compared against the head of that instance's scoreboard queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (track_pkts) begin
                check_output("pkts_a_vs_model", pkts_a, exp_pkts_a);
                check_output("pkts_s_vs_model", pkts_s, exp_pkts_s);
                if (full_a || full_s)
                    seen_full = 1'b1;
            end
            if (rd_a && !empty_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_a: got unexpected word 0x%0h, expected no word", data_a);
                end else begin
                    w_a = q_a.pop_front();
                    check_output("data_a", data_a, w_a[BW-1:0]);
                    check_output("last_a", last_a, w_a[BW]);
                    if (w_a[BW])
                        exp_pkts_a--;
                end
            end
            if (rd_s && !empty_s) begin
                if (q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pop_s: got unexpected word 0x%0h, expected no word", data_s);
                end else begin
                    w_s = q_s.pop_front();
                    check_output("data_s", data_s, w_s[BW-1:0]);
                    check_output("last_s", last_s, w_s[BW]);
                    if (w_s[BW])
                        exp_pkts_s--;
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        last    = 1'b0;
        abort   = 1'b0;
        rd_a    = 1'b0;
        rd_s    = 1'b0;
        data    = '0;
        thresh  = '0;
        tick();
        tick();
        check_reset(1'b1);
        thresh = 5;
        #1;
        check_output("afull_thresh5_empty", afull_a, 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] 4-word packet commit latency");
        for (int i = 0; i < 4; i++) begin
            put_word(32'h10 + BW'(i), i == 3);
            check_output("t1_empty_a", empty_a, (i < 3));
        end
        for (int i = 0; i < 4; i++)
            push_word({i == 3, 32'h10 + BW'(i)});
        check_output("t1_empty_s_commit+1", empty_s, 1);
        check_output("t1_pkts_a", pkts_a, 1);
        check_output("t1_rd_fill_a", rd_fill_a, 4);
        tick();
        check_output("t1_empty_s_commit+2", empty_s, 0);
        check_output("t1_pkts_s", pkts_s, 1);
        check_output("t1_rd_fill_s", rd_fill_s, 4);
        drain();
        check_output("t1_pkts_a_drained", pkts_a, 0);

        $display("[TB] abort discards the open packet");
        for (int i = 0; i < 3; i++)
            put_word(32'h20 + BW'(i), 1'b0);
        check_output("t2_wr_fill_3", wr_fill_a, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t2_wr_fill_abort", wr_fill_a, 0);
        check_output("t2_empty_a", empty_a, 1);
        check_output("t2_pkts_a", pkts_a, 0);
        abort = 1'b1;
        put_word(32'h2F, 1'b1);
        abort = 1'b0;
        check_output("t2_abort_beats_last_fill", wr_fill_a, 0);
        check_output("t2_abort_beats_last_pkts", pkts_s, 0);
        send_pkt(32'hA5, 1);
        drain();

        $display("[TB] overflow drops the open packet only");
        send_pkt(32'h300, 10);
        for (int i = 0; i < 6; i++)
            put_word(32'h400 + BW'(i), 1'b0);
        check_output("t3_full_a", full_a, 1);
        check_output("t3_full_s", full_s, 1);
        check_output("t3_wr_fill_16", wr_fill_a, FLEN);
        check_output("t3_afull_a", afull_a, 1);
        put_word(32'h406, 1'b0);
        check_output("t3_overflow_a", overflow_a, 1);
        check_output("t3_overflow_s", overflow_s, 1);
        check_output("t3_wr_fill_a_rewound", wr_fill_a, 10);
        check_output("t3_full_a_cleared", full_a, 0);
        put_word(32'h407, 1'b0);
        put_word(32'h408, 1'b0);
        put_word(32'h409, 1'b1);
        check_output("t3_wr_fill_a_dropped", wr_fill_a, 10);
        check_output("t3_wr_fill_s_dropped", wr_fill_s, 10);
        check_output("t3_pkts_a", pkts_a, 1);
        drain();
        send_pkt(32'h450, 2);
        check_output("t3_accept_after_drop", wr_fill_a, 2);
        drain();

        $display("[TB] streaming through pointer wrap");
        track_pkts = 1'b1;
        rd_a = 1'b1;
        rd_s = 1'b1;
        for (int p = 0; p < 10; p++)
            send_pkt(32'h800 + BW'(p * 5), 5);
        drain();
        track_pkts = 1'b0;
        check_output("t4_never_full", seen_full, 0);
        check_output("t4_pkts_a_end", pkts_a, 0);
        check_output("t4_pkts_s_end", pkts_s, 0);

        $display("[TB] registered-read latency and same-cycle pop/commit");
        send_pkt(32'h500, 1);
        check_output("t5_empty_s_commit+1", empty_s, 1);
        tick();
        check_output("t5_empty_s_commit+2", empty_s, 0);
        check_output("t5_data_s_head", data_s, 32'h500);
        put_word(32'h600, 1'b0);
        rd_s = 1'b1;
        put_word(32'h601, 1'b1);
        push_word({1'b0, 32'h600});
        push_word({1'b1, 32'h601});
        check_output("t5_pkts_s_pop_and_commit", pkts_s, 1);
        check_output("t5_empty_s_gap", empty_s, 1);
        tick();
        check_output("t5_b0_valid", empty_s, 0);
        check_output("t5_b0_data", data_s, 32'h600);
        tick();
        check_output("t5_b1_no_bubble", empty_s, 0);
        check_output("t5_b1_data", data_s, 32'h601);
        check_output("t5_b1_last", last_s, 1);
        tick();
        rd_s = 1'b0;
        check_output("t5_s_empty_after", empty_s, 1);
        drain();
        send_pkt(32'h700, 1);
        rd_a = 1'b1;
        put_word(32'h701, 1'b1);
        rd_a = 1'b0;
        push_word({1'b1, 32'h701});
        check_output("t5_async_pop_commit_empty", empty_a, 0);
        check_output("t5_async_pop_commit_data", data_a, 32'h701);
        check_output("t5_wr_pop_fill_unchanged", wr_fill_a, 1);
        drain();

        $display("[TB] reset mid-packet and almost-full threshold");
        send_pkt(32'hB00, 2);
        send_pkt(32'hB10, 2);
        put_word(32'hC00, 1'b0);
        reset_n = 1'b0;
        put_word(32'hC01, 1'b0);
        check_reset(1'b0);
        q_a.delete();
        q_s.delete();
        exp_pkts_a = 0;
        exp_pkts_s = 0;
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            put_word(32'hD00 + BW'(k), 1'b0);
            check_output("t6_wr_fill", wr_fill_a, k);
            check_output("t6_afull_a", afull_a, (k >= 5));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("t6_abort_fill", wr_fill_s, 0);
        check_output("t6_queue_a_left", q_a.size(), 0);
        check_output("t6_queue_s_left", q_s.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
